// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32 unsigned shift-and-add multiplier: one add_opr per cycle, 32 iterations.
// Latency 33 cycles start-to-done; start is only honoured in IDLE, abort cancels at any time.

module add_opr #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  // Explicit ripple chain; the carry is a block-local variable so the chain has no feedback.
  always_comb begin
    logic c;
    c   = ci;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;

  add_opr #(.W(WIDTH)) u_add (
    .a   (r_hi),
    .b   (r_mcand),
    .ci  (1'b0),
    .sum (w_sum),
    .co  (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // The adder carry becomes the new hi[MSB], so the 64-bit product is never truncated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else if (abort) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (r_lo[0]) begin
            {r_hi, r_lo} <= {w_co, w_sum, r_lo[WIDTH-1:1]};
          end else begin
            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner products, start/abort/reset
// interactions and a random back-to-back run checked against a 64-bit arithmetic model.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Issues one start, then watches until done (bounded to 40 cycles).
  task automatic run_mult(input logic [31:0] av, input logic [31:0] bv,
                          output logic [63:0] prod, output int busy_cnt,
                          output int done_cnt, output int acc_cyc);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    busy_cnt = 0; done_cnt = 0; prod = '0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        prod = {hi, lo};
      end
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] prod;
    int bc, dc, acc;
    ta[0] = 32'd3;          tb[0] = 32'd5;
    ta[1] = 32'hFFFFFFFF;   tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'h12345678;   tb[2] = 32'd0;
    ta[3] = 32'h80000000;   tb[3] = 32'd2;
    for (int t = 0; t < 4; t++) begin
      run_mult(ta[t], tb[t], prod, bc, dc, acc);
      vectors++;
      if (prod !== ref_prod(ta[t], tb[t])) begin
        miscompares++;
        $display("FAIL directed_product[%0d]: got %h want %h", t, prod, ref_prod(ta[t], tb[t]));
      end
      vectors++;
      if (bc != 32 || dc != 1) begin
        miscompares++;
        $display("FAIL directed_timing[%0d]: got busy_cycles=%0d dones=%0d want 32 and 1", t, bc, dc);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== ref_prod(ta[t], tb[t])) begin
        miscompares++;
        $display("FAIL directed_hold[%0d]: got done=%b busy=%b hilo=%h want 0 0 %h",
                 t, done, busy, {hi, lo}, ref_prod(ta[t], tb[t]));
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [31:0] av, bv;
    logic [63:0] exp, prod;
    int busy_bad, done_cnt;
    av = $urandom; bv = $urandom;
    exp = ref_prod(av, bv);
    prod = '0; busy_bad = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy !== (k <= 32)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (k == 33) prod = {hi, lo};
      end
      start = (k == 5 || k == 20 || k == 32 || k == 33);
      a = $urandom; b = $urandom;
    end
    start = 1'b0;
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL sdr_busy_continuous: got %0d bad busy samples want 0", busy_bad);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL sdr_done_once: got %0d done pulses want 1", done_cnt);
    end
    vectors++;
    if (prod !== exp || {hi, lo} !== exp) begin
      miscompares++;
      $display("FAIL sdr_product: got at_done=%h now=%h want %h", prod, {hi, lo}, exp);
    end
  endtask

  task automatic test_abort();
    logic [31:0] av, bv;
    logic [63:0] prod;
    int bc, dc, acc;
    av = $urandom | 32'h1; bv = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_clears: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    av = $urandom; bv = $urandom;
    run_mult(av, bv, prod, bc, dc, acc);
    vectors++;
    if (prod !== ref_prod(av, bv) || bc != 32 || dc != 1) begin
      miscompares++;
      $display("FAIL abort_restart: got prod=%h busy=%0d dones=%0d want %h 32 1",
               prod, bc, dc, ref_prod(av, bv));
    end
    // start and abort together in IDLE: abort must win
    @(negedge clk);
    start = 1'b1; abort = 1'b1; a = $urandom; b = $urandom;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    dc = 0; bc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    vectors++;
    if (bc != 0 || dc != 0 || {hi, lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL abort_beats_start: got busy=%0d done=%0d hilo=%h want 0 0 0", bc, dc, {hi, lo});
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] av, bv;
    logic [63:0] prod;
    int bc, dc, acc;
    @(negedge clk);
    start = 1'b1; a = 32'hDEADBEEF; b = 32'hFFFF0003;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    av = $urandom; bv = $urandom;
    run_mult(av, bv, prod, bc, dc, acc);
    vectors++;
    if (prod !== ref_prod(av, bv) || bc != 32 || dc != 1) begin
      miscompares++;
      $display("FAIL async_reset_resume: got prod=%h busy=%0d dones=%0d want %h 32 1",
               prod, bc, dc, ref_prod(av, bv));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv;
    logic [63:0] prod;
    int bc, dc, acc, prev_acc;
    prev_acc = 0;
    for (int n = 0; n < 1000; n++) begin
      av = $urandom; bv = $urandom;
      if (n == 0) begin av = 32'hFFFFFFFF; bv = 32'h7FFFFFFF; end
      run_mult(av, bv, prod, bc, dc, acc);
      vectors++;
      if (prod !== ref_prod(av, bv)) begin
        miscompares++;
        $display("FAIL b2b_product[%0d]: a=%h b=%h got %h want %h", n, av, bv, prod, ref_prod(av, bv));
      end
      vectors++;
      if (bc != 32 || dc != 1) begin
        miscompares++;
        $display("FAIL b2b_timing[%0d]: got busy=%0d dones=%0d want 32 1", n, bc, dc);
      end
      if (n > 0) begin
        vectors++;
        if (acc - prev_acc != 34) begin
          miscompares++;
          $display("FAIL b2b_interval[%0d]: got %0d cycles want 34", n, acc - prev_acc);
        end
      end
      prev_acc = acc;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_during_run();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential 32x32 unsigned multiplier controller for the MIPS datapath. It executes `multu` by reusing a single 32-bit ripple-carry adder (`add_opr`) over 32 shift-and-add iterations. It accepts a start pulse from the main control unit and reports busy/done. It leaves the 64-bit product in HI/LO-style registers for `mfhi`/`mflo`.

## Interface

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH. Only 32 is supported, to match `add_opr`.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- abort  input  1  cancel the operation in progress. Highest priority after reset.
- a  input  32  multiplicand, captured on the accepted start.
- b  input  32  multiplier, captured on the accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; hi/lo hold the final product.
- hi  output  32  upper product word; registered.
- lo  output  32  lower product word; registered.

## Operation

Internal registers:
- mcand[31:0]
- hi[31:0]
- lo[31:0]
- cnt[4:0]
- 2-bit state: IDLE, RUN, DONE.

Adder:
- One `add_opr` instance, with a = hi, b = mcand, ci = 0.
- Outputs are sum[31:0] and co.

IDLE:
- busy = 0, done = 0. hi/lo hold their last value.
- start = 1 loads mcand ← a, hi ← 0, lo ← b, cnt ← 0, then state → RUN.

RUN (one iteration per cycle):
- If lo[0] = 1: {hi, lo} ← {co, sum, lo[31:1]}.
- Else: {hi, lo} ← {1'b0, hi, lo[31:1]}.
- cnt ← cnt + 1.
- When cnt = 31, the iteration completes and state → DONE.
- start is ignored while in RUN.

DONE:
- done = 1 for exactly this cycle. hi/lo = a × b.
- state → IDLE unconditionally. start is ignored in DONE.

Arithmetic:
- Unsigned only; the product is exact 64-bit.
- The adder carry out is the 33rd bit of the partial sum and is shifted into hi[31]. It is never dropped.

Abort:
- abort = 1 in any state: state → IDLE, hi ← 0, lo ← 0, cnt ← 0, and no done pulse.
- If start and abort are high in the same IDLE cycle, abort wins and the start is not accepted.

Reset:
- rst_n low asynchronously forces state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, mcand = 0, cnt = 0.
- This applies mid-operation too; the operation is lost.

## Timing

Latency:
- start accepted at rising edge E0.
- busy = 1 during the 32 cycles following E0, from edge E0 to edge E32.
- done = 1 during the cycle following edge E32.
- Final hi/lo are valid from edge E32 and held until the next accepted start, abort or reset.

Issue rate:
- The earliest next start is accepted at edge E34, i.e. in the first IDLE cycle after done.
- Throughput is one multiply per 34 cycles.

Output and adder timing:
- busy and done are decoded from registered state only. They never depend combinationally on start.
- The critical path is the 32-bit ripple through `add_opr` plus the result mux into hi. This must close within one clk period.
- hi/lo change every RUN cycle. Consumers must sample them only on done or later.

## Test plan

- Basic: a = 3, b = 5, one-cycle start → busy high for 32 cycles, then done for 1 cycle with hi = 0x00000000, lo = 0x0000000F. Then IDLE.
- Carry path: a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Confirms co is shifted into hi[31].
- Zero and identity cases:
  - a = 0x12345678, b = 0 → hi = lo = 0.
  - a = 0x80000000, b = 2 → hi = 0x00000001, lo = 0.
- Start during operation: start at cycles 5, 20 and 32 after acceptance, with different operands → ignored. The first product is unchanged, done fires exactly once, and busy is continuous.
- Abort and reset:
  - abort at iteration 10 → busy drops the next cycle, no done, hi = lo = 0.
  - A new start two cycles later completes correctly.
  - rst_n asserted asynchronously mid-RUN (between edges) → all outputs 0 immediately. Normal operation resumes after release.
- Back-to-back: 1000 random a/b pairs, each start issued in the first IDLE cycle after done → every {hi, lo} equals the 64-bit reference product. Measured issue interval is 34 cycles.
